// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the line-granular backing data memory.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package dmem_pkg;

  localparam int ADDR_W   = 32;   // byte address width from the cache controller
  localparam int LINE_W   = 256;  // one cache line, 32 bytes
  localparam int OFFSET_W = 5;    // byte-in-line offset bits, ignored by the memory
  localparam int DEPTH    = 512;  // lines stored
  localparam int LATENCY  = 10;   // request edge to ack, legal 2..255
  localparam int CNT_W    = 8;    // wait counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port line storage: one line write or one line read per edge.
// Latency: read data registered, visible the cycle after the read edge.
// Backpressure: none; the owner sequences accesses and holds the read register.
module dmem_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);
  import dmem_pkg::*;

  // Storage contents survive reset; only the read register is cleared.
  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] rdata_d;

  // Read register only changes on a read, so it holds the last line read.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[idx_i];
    end
  end

  // Read register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Line write port; caller gates the enable with reset so aborted writes never land.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Backing memory behind the data cache: one 256-bit line read or write per request.
// Latency: ack_o pulses exactly LATENCY cycles after the accepting edge.
// Backpressure: enable_i is held by the requester until ack_o; new requests wait for IDLE.
module data_memory #(
  parameter int ADDR_W  = dmem_pkg::ADDR_W,
  parameter int LINE_W  = dmem_pkg::LINE_W,
  parameter int DEPTH   = dmem_pkg::DEPTH,
  parameter int LATENCY = dmem_pkg::LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);
  import dmem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  // Edges spent in WAIT before the commit edge: the accept edge is E0, the
  // counter reaches zero at E(LATENCY-1), and the edge seen with zero is the
  // commit edge E(LATENCY). LATENCY must stay within 2..255.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              commit;
  logic              arr_we;
  logic              arr_re;

  // Offset and upper address bits are intentionally dropped (upper bits alias).
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  // Next-state logic: accept in IDLE, count down in WAIT, single ACK cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[OFFSET_W +: IDX_W];
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Inputs are ignored here; only the latched request matters.
        if (cnt_q == '0) begin
          commit  = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        // The requester drops enable_i on this edge, so IDLE sees a fresh request only.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset edge must not let a pending write reach the array.
  assign arr_we = commit && wr_q && rst_i;
  assign arr_re = commit && !wr_q;

  // Control and latched-request registers; reset aborts any request in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  dmem_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

  assign ack_o = ack_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: table of line requests plus
// hand-built sequences for mid-request input changes, reset abort and
// back-to-back acceptance with enable held high.
module tb_data_memory;

  typedef logic [255:0] line_t;

  typedef struct {
    string       name;
    logic        w;
    logic [31:0] addr;
    line_t       din;
    line_t       exp_dout;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [31:0] addr;
  line_t       din;
  logic        ack;
  line_t       dout;

  int checks;
  int errors;

  localparam line_t LA5 = {32{8'hA5}};
  localparam line_t L1  = {8{32'h12345678}};
  localparam line_t L2  = {8{32'hDEADBEEF}};
  localparam line_t L3  = {8{32'h0BADF00D}};
  localparam line_t L4  = {8{32'hCAFE0004}};
  localparam line_t L5  = {8{32'h55AA1234}};
  localparam line_t L6  = {8{32'h66666666}};

  data_memory dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
    .write_i  (wr),
    .addr_i   (addr),
    .data_i   (din),
    .ack_o    (ack),
    .data_o   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_line(input string name, input line_t got, input line_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One request. Cycle n is sampled on the falling edge after rising edge En,
  // E0 being the accepting edge. If chg_at >= 0 the address, data and write
  // inputs are scrambled after sampling cycle chg_at (request is in WAIT).
  task automatic run_req(input string name, input logic w, input logic [31:0] a,
                         input line_t d, input int chg_at,
                         output int lat, output line_t rd);
    @(negedge clk);
    en   = 1'b1;
    wr   = w;
    addr = a;
    din  = d;
    lat  = -1;
    rd   = '0;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (ack) begin
        lat = n;
        rd  = dout;
        break;
      end
      if (n == chg_at) begin
        addr = 32'h40;
        din  = '0;
        wr   = ~w;
      end
    end
    en = 1'b0;
    @(negedge clk);
    chk_int({name, "_ack_low_after"}, int'(ack), 0);
  endtask

  vec_t  vecs [9];
  int    lat;
  line_t rd;
  int    ack_cnt;
  int    rise1;
  int    fall1;
  int    rise2;
  logic  prev_ack;

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b0;
    en   = 1'b0;
    wr   = 1'b0;
    addr = '0;
    din  = '0;

    // Writes leave data_o untouched, so each write expects the previous read line.
    vecs[0] = '{"wr_idx3_a5",   1'b1, 32'h0000_0060, LA5, '0,  10};
    vecs[1] = '{"rd_idx3_a5",   1'b0, 32'h0000_0060, '0,  LA5, 10};
    vecs[2] = '{"wr_0x80_l1",   1'b1, 32'h0000_0080, L1,  LA5, 10};
    vecs[3] = '{"rd_0x9f_l1",   1'b0, 32'h0000_009F, '0,  L1,  10};
    vecs[4] = '{"wr_0x4000_l2", 1'b1, 32'h0000_4000, L2,  L1,  10};
    vecs[5] = '{"rd_0x0_alias", 1'b0, 32'h0000_0000, '0,  L2,  10};
    vecs[6] = '{"wr_0x100_l3",  1'b1, 32'h0000_0100, L3,  L2,  10};
    vecs[7] = '{"rd_0x100_l3",  1'b0, 32'h0000_0100, '0,  L3,  10};
    vecs[8] = '{"wr_0x40_l4",   1'b1, 32'h0000_0040, L4,  L3,  10};

    // Reset values
    repeat (3) @(negedge clk);
    chk_int("rst_ack", int'(ack), 0);
    chk_line("rst_dout", dout, '0);
    rst = 1'b1;
    @(negedge clk);
    chk_int("idle_ack", int'(ack), 0);
    chk_line("idle_dout", dout, '0);

    // Table-driven requests
    foreach (vecs[i]) begin
      run_req(vecs[i].name, vecs[i].w, vecs[i].addr, vecs[i].din, -1, lat, rd);
      chk_int({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      chk_line({vecs[i].name, "_dout"}, rd, vecs[i].exp_dout);
    end

    // Inputs changed during WAIT of a write to 0x80: index 4 gets L5, index 2 keeps L4
    run_req("wr_0x80_chg", 1'b1, 32'h0000_0080, L5, 3, lat, rd);
    chk_int("wr_0x80_chg_lat", lat, 10);
    run_req("rd_0x80_chg", 1'b0, 32'h0000_0080, '0, -1, lat, rd);
    chk_int("rd_0x80_chg_lat", lat, 10);
    chk_line("rd_0x80_chg_dout", rd, L5);
    run_req("rd_0x40_chg", 1'b0, 32'h0000_0040, '0, -1, lat, rd);
    chk_int("rd_0x40_chg_lat", lat, 10);
    chk_line("rd_0x40_chg_dout", rd, L4);

    // Reset at cycle 5 of a write to 0x100: aborted, no ack, data_o cleared
    @(negedge clk);
    en   = 1'b1;
    wr   = 1'b1;
    addr = 32'h0000_0100;
    din  = L6;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    ack_cnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
    end
    chk_int("abort_no_ack", ack_cnt, 0);
    chk_line("abort_dout_cleared", dout, '0);
    run_req("rd_0x100_after_abort", 1'b0, 32'h0000_0100, '0, -1, lat, rd);
    chk_int("rd_0x100_after_abort_lat", lat, 10);
    chk_line("rd_0x100_after_abort_dout", rd, L3);

    // enable held through ACK and one more cycle: second request accepted at the
    // first IDLE edge, so ack falls at n=11 and the second ack rises 11 cycles later
    @(negedge clk);
    en   = 1'b1;
    wr   = 1'b0;
    addr = 32'h0000_0080;
    din  = '0;
    rise1 = -1;
    fall1 = -1;
    rise2 = -1;
    ack_cnt = 0;
    prev_ack = 1'b0;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
      if (ack && !prev_ack) begin
        if (rise1 < 0) rise1 = n;
        else if (rise2 < 0) rise2 = n;
      end
      if (!ack && prev_ack && fall1 < 0) fall1 = n;
      prev_ack = ack;
      if (rise2 >= 0) begin
        en = 1'b0;
        break;
      end
    end
    en = 1'b0;
    @(negedge clk);
    chk_int("hold_rise1", rise1, 10);
    chk_int("hold_fall1", fall1, 11);
    chk_int("hold_rise2", rise2, 22);
    chk_int("hold_fall_to_rise", rise2 - fall1, 11);
    chk_int("hold_ack_cycles", ack_cnt, 2);
    chk_line("hold_dout", dout, L5);
    chk_int("hold_ack_low_after", int'(ack), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
